// File: rtl/peripheral_adder_apb4_slave.sv
// APB4 slave around a bit-serial adder: two operand registers, a start/irq-enable
// control register, a status register and a result register that stalls reads while busy.
module peripheral_adder_apb4_slave #(
    parameter int PADDR_WIDTH   = 8,
    parameter int PDATA_WIDTH   = 32,
    parameter int OPERAND_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [PADDR_WIDTH-1:0]   paddr,
    input  logic [PDATA_WIDTH-1:0]   pwdata,
    input  logic [PDATA_WIDTH/8-1:0] pstrb,
    output logic [PDATA_WIDTH-1:0]   prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic                     irq
);

    localparam int OW = OPERAND_WIDTH;
    localparam int CW = $clog2(OPERAND_WIDTH) + 1;
    localparam int IW = PADDR_WIDTH - 2;

    localparam logic [IW-1:0] IDX_OP1    = IW'(0);
    localparam logic [IW-1:0] IDX_OP2    = IW'(1);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(2);
    localparam logic [IW-1:0] IDX_STATUS = IW'(3);
    localparam logic [IW-1:0] IDX_RESULT = IW'(4);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   op1_q, op1_d;
    logic [OW-1:0]   op2_q, op2_d;
    logic [OW-1:0]   sh1_q, sh1_d;
    logic [OW-1:0]   sh2_q, sh2_d;
    logic [OW:0]     result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            done_q, done_d;
    logic            irq_en_q, irq_en_d;

    logic [IW-1:0]   widx;
    logic            sel_op1, sel_op2, sel_ctrl, sel_status, sel_result, unmapped;
    logic            busy, access, complete, wr_err, wr_ok, start;
    logic            sum_bit, carry_out;
    logic [OW-1:0]   op_mask;
    logic [OW-1:0]   op_wdata;
    logic            unused_bits;

    // Expand byte-lane strobes to a per-bit mask over the operand width
    generate
        for (genvar gi = 0; gi < OW; gi++) begin : g_op_mask
            assign op_mask[gi] = pstrb[gi/8];
        end
    endgenerate

    assign op_wdata    = pwdata[OW-1:0] & op_mask;
    assign unused_bits = ^{paddr[1:0], pwdata, pstrb};

    assign widx       = paddr[PADDR_WIDTH-1:2];
    assign sel_op1    = (widx == IDX_OP1);
    assign sel_op2    = (widx == IDX_OP2);
    assign sel_ctrl   = (widx == IDX_CTRL);
    assign sel_status = (widx == IDX_STATUS);
    assign sel_result = (widx == IDX_RESULT);
    assign unmapped   = ~(sel_op1 | sel_op2 | sel_ctrl | sel_status | sel_result);

    assign busy     = (state_q == RUN);
    assign access   = psel & penable;
    assign pready   = ~(access & ~pwrite & sel_result & busy);
    assign complete = access & pready;
    assign wr_err   = pwrite & (sel_result | (busy & (sel_op1 | sel_op2 | sel_ctrl)));
    assign pslverr  = complete & (unmapped | wr_err);
    assign wr_ok    = complete & pwrite & ~unmapped & ~wr_err;
    assign start    = wr_ok & sel_ctrl & pstrb[0] & pwdata[0];
    assign irq      = done_q & irq_en_q;

    assign sum_bit   = sh1_q[0] ^ sh2_q[0] ^ carry_q;
    assign carry_out = (sh1_q[0] & sh2_q[0]) | (carry_q & (sh1_q[0] ^ sh2_q[0]));

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (1'b1)
                sel_op1:    prdata = PDATA_WIDTH'(op1_q);
                sel_op2:    prdata = PDATA_WIDTH'(op2_q);
                sel_ctrl:   prdata = PDATA_WIDTH'({irq_en_q, 1'b0});
                sel_status: prdata = PDATA_WIDTH'({carry_q, done_q, busy});
                sel_result: prdata = PDATA_WIDTH'(result_q);
                default:    prdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;

        if (wr_ok && sel_op1) op1_d = (op1_q & ~op_mask) | op_wdata;
        if (wr_ok && sel_op2) op2_d = (op2_q & ~op_mask) | op_wdata;
        if (wr_ok && sel_ctrl && pstrb[0]) irq_en_d = pwdata[1];
        if (wr_ok && sel_status && pstrb[0] && pwdata[1]) done_d = 1'b0;

        // The done-set below comes after the W1C clear so a same-edge set wins
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh1_d   = op1_q;
                    sh2_d   = op2_q;
                    carry_d = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh1_d    = sh1_q >> 1;
                sh2_d    = sh2_q >> 1;
                carry_d  = carry_out;
                result_d = {carry_out, sum_bit, result_q[OW-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(OW - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            sh1_q    <= '0;
            sh2_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
        end
    end

endmodule

// File: tb/tb_peripheral_adder_apb4_slave.sv
// Directed bench for the APB4 bit-serial adder slave; expected transfer results are
// queued before each transfer and popped for comparison when the transfer completes.
module tb_peripheral_adder_apb4_slave;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int n_cmp = 0;
    int n_mis = 0;
    int last_waits = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    peripheral_adder_apb4_slave #(
        .PADDR_WIDTH  (8),
        .PDATA_WIDTH  (32),
        .OPERAND_WIDTH(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rdat,
                        output logic err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        #3;
        while (!pready && waits < 64) begin
            waits++;
            @(posedge clk); #4;
        end
        if (!pready) begin
            n_cmp++;
            n_mis++;
            $error("FAIL timeout: pready observed 0 expected 1 within 64 cycles");
        end
        rdat = prdata;
        err  = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp_d,
                      input logic exp_e, input int exp_waits = -1);
        exp_t        e;
        logic [31:0] d;
        logic        er;
        int          w;
        sb.push_back('{tag, exp_d, exp_e});
        xfer(1'b0, addr, 32'h0, 4'h0, d, er, w);
        last_waits = w;
        e = sb.pop_front();
        check({e.tag, "_data"}, d, e.data);
        check({e.tag, "_err"}, 32'(er), 32'(e.err));
        if (exp_waits >= 0) check({e.tag, "_waits"}, 32'(w), 32'(exp_waits));
    endtask

    task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                      input logic exp_e, input logic [3:0] strb = 4'hF);
        exp_t        e;
        logic [31:0] d;
        logic        er;
        int          w;
        sb.push_back('{tag, 32'h0, exp_e});
        xfer(1'b1, addr, data, strb, d, er, w);
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(er), 32'(e.err));
    endtask

    initial begin
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        #2;
        check("rst_pready", 32'(pready), 32'h1);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // All registers read zero after reset, no wait states
        rd("r0_op1",    8'h00, 32'h0, 1'b0, 0);
        rd("r0_op2",    8'h04, 32'h0, 1'b0, 0);
        rd("r0_ctrl",   8'h08, 32'h0, 1'b0, 0);
        rd("r0_status", 8'h0C, 32'h0, 1'b0, 0);
        rd("r0_result", 8'h10, 32'h0, 1'b0, 0);

        // 0xFF + 0x01 with exact latency check
        wr("a_op1", 8'h00, 32'hFF, 1'b0);
        wr("a_op2", 8'h04, 32'h01, 1'b0);
        wr("a_start", 8'h08, 32'h1, 1'b0);
        repeat (5) @(posedge clk);
        begin
            logic [31:0] d; logic er; int w;
            xfer(1'b0, 8'h0C, 32'h0, 4'h0, d, er, w);
            check("a_busy_edge7", d & 32'h1, 32'h1);
        end
        rd("a_status", 8'h0C, 32'h6, 1'b0);
        rd("a_result", 8'h10, 32'h100, 1'b0, 0);
        rd("a_op1", 8'h00, 32'hFF, 1'b0);

        // RESULT read right after start stalls until the sum is final
        wr("b_op1", 8'h00, 32'h12, 1'b0);
        wr("b_op2", 8'h04, 32'h34, 1'b0);
        wr("b_start", 8'h08, 32'h1, 1'b0);
        rd("b_result", 8'h10, 32'h046, 1'b0, 6);

        // Operand write while busy is rejected
        wr("c_op1", 8'h00, 32'h0F, 1'b0);
        wr("c_op2", 8'h04, 32'h01, 1'b0);
        wr("c_start", 8'h08, 32'h1, 1'b0);
        wr("c_op1_busy", 8'h00, 32'hAA, 1'b1);
        rd("c_op1_rd", 8'h00, 32'h0F, 1'b0);
        rd("c_result", 8'h10, 32'h010, 1'b0);
        check("c_irq_off", 32'(irq), 32'h0);

        // Unmapped and read-only accesses, ignored address LSBs, zero strobes
        rd("d_unmapped", 8'h14, 32'h0, 1'b1);
        rd("d_unmapped_hi", 8'hFC, 32'h0, 1'b1);
        wr("d_wr_result", 8'h10, 32'h55, 1'b1);
        rd("d_result", 8'h10, 32'h010, 1'b0);
        rd("d_op1_lsb", 8'h03, 32'h0F, 1'b0);
        wr("d_op2_nostrb", 8'h04, 32'hEE, 1'b0, 4'h0);
        rd("d_op2", 8'h04, 32'h01, 1'b0);

        // Interrupt path and maximum sum
        wr("e_irq_en", 8'h08, 32'h2, 1'b0);
        rd("e_ctrl", 8'h08, 32'h2, 1'b0);
        wr("e_op1", 8'h00, 32'hFF, 1'b0);
        wr("e_op2", 8'h04, 32'hFF, 1'b0);
        wr("e_start", 8'h08, 32'h3, 1'b0);
        repeat (7) @(posedge clk);
        #1 check("e_irq_edge7", 32'(irq), 32'h0);
        @(posedge clk);
        #1 check("e_irq_edge8", 32'(irq), 32'h1);
        rd("e_result", 8'h10, 32'h1FE, 1'b0);
        rd("e_status", 8'h0C, 32'h6, 1'b0);
        rd("e_ctrl2", 8'h08, 32'h2, 1'b0);
        wr("e_w1c", 8'h0C, 32'h2, 1'b0);
        #1 check("e_irq_clr", 32'(irq), 32'h0);
        rd("e_status_clr", 8'h0C, 32'h4, 1'b0);

        // W1C landing on the same edge as done-set leaves done set
        wr("f_start", 8'h08, 32'h3, 1'b0);
        repeat (5) @(posedge clk);
        wr("f_w1c_collide", 8'h0C, 32'h2, 1'b0);
        rd("f_status", 8'h0C, 32'h6, 1'b0);
        check("f_irq", 32'(irq), 32'h1);

        // Reset in the middle of a run aborts it
        wr("g_start", 8'h08, 32'h3, 1'b0);
        wr("g_ctrl_busy", 8'h08, 32'h2, 1'b1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("g_irq_rst", 32'(irq), 32'h0);
        check("g_pready_rst", 32'(pready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        rd("g_status", 8'h0C, 32'h0, 1'b0);
        rd("g_result", 8'h10, 32'h0, 1'b0, 0);
        rd("g_ctrl", 8'h08, 32'h0, 1'b0);
        rd("g_op1", 8'h00, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
